instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction prefetch unit: fetch FSM feeding a DEPTH-entry queue.
// Define FETCH_STATS_EN to add the fetch_cnt completed-read counter.
module instr_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] adr_bus,
  output logic              rd_mem,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_rdy,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  input  logic              flush,
`ifdef FETCH_STATS_EN
  input  logic [ADDR_W-1:0] flush_pc,
  output logic [31:0]       fetch_cnt
`else
  input  logic [ADDR_W-1:0] flush_pc
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nx;
  logic [ADDR_W-1:0] r_redir;
  logic [ADDR_W-1:0] w_redir_nx;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_after;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_tag  [DEPTH];
  logic              w_push;
  logic              w_pop;
  logic              w_done;
  logic              w_valid;

  assign w_valid = (r_count != '0);
  assign w_done  = (r_state != IDLE) && mem_rdy;
  assign w_pop   = w_valid && ins_ready && !flush;
  assign w_push  = (r_state == REQ) && mem_rdy && !flush;

  assign w_count_after = r_count
                       + CW'(w_push)
                       - CW'(w_pop);

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_redir_nx = r_redir;
    unique case (r_state)
      IDLE: begin
        if (flush) begin
          w_pc_nx = flush_pc;
        end else if (r_count < FULL) begin
          w_state_nx = REQ;
        end
      end
      REQ: begin
        if (flush && mem_rdy) begin
          w_pc_nx = flush_pc;
        end else if (flush) begin
          // bus must keep the old address until that read retires
          w_state_nx = DISCARD;
          w_redir_nx = flush_pc;
        end else if (mem_rdy) begin
          w_pc_nx = r_pc + ADDR_W'(1);
          if (w_count_after == FULL) begin
            w_state_nx = IDLE;
          end
        end
      end
      DISCARD: begin
        if (flush) begin
          w_redir_nx = flush_pc;
        end
        if (mem_rdy) begin
          w_state_nx = REQ;
          w_pc_nx    = flush ? flush_pc : r_redir;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_redir <= RESET_PC;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_redir <= w_redir_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= mem_data;
      r_tag[r_wr_ptr]  <= r_pc;
    end
  end

  assign rd_mem    = (r_state != IDLE);
  assign adr_bus   = r_pc;
  assign ins_valid = w_valid;
  assign ins_data  = w_valid ? r_data[r_rd_ptr] : '0;
  assign ins_pc    = w_valid ? r_tag[r_rd_ptr]  : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_done && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_cnt;
`else
  logic w_unused;
  assign w_unused = w_done;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random traffic
// checked against a queue-level model of the fetch rules.
module tb_instr_fetch_unit;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] adr_bus;
  logic          rd_mem;
  logic [DW-1:0] mem_data;
  logic          mem_rdy = 1'b0;
  logic          ins_valid;
  logic [DW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          ins_ready = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
`ifdef FETCH_STATS_EN
  logic [31:0]   fetch_cnt;
`endif

  instr_fetch_unit #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH(DEPTH),
    .RESET_PC('0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adr_bus(adr_bus),
    .rd_mem(rd_mem),
    .mem_data(mem_data),
    .mem_rdy(mem_rdy),
    .ins_valid(ins_valid),
    .ins_data(ins_data),
    .ins_pc(ins_pc),
    .ins_ready(ins_ready),
`ifdef FETCH_STATS_EN
    .flush(flush),
    .flush_pc(flush_pc),
    .fetch_cnt(fetch_cnt)
`else
    .flush(flush),
    .flush_pc(flush_pc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [31:0] p;
    p = {16'h0, a} * 32'h9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  assign mem_data = memf(adr_bus);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_hold;
  bit            m_req;
  bit            m_disc;
  logic [31:0]   m_cnt;
  int            n_assert = 0;
  int            n_fail = 0;
  int            n_done = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_pc   = '0;
    m_hold = '0;
    m_req  = 0;
    m_disc = 0;
    m_cnt  = '0;
  endtask

  task automatic check_outputs();
    chk("ins_valid", {31'b0, ins_valid},
        {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("ins_pc", {16'b0, ins_pc}, {16'b0, q[0].pc});
      chk("ins_data", {16'b0, ins_data}, {16'b0, q[0].d});
    end
    chk("rd_mem", {31'b0, rd_mem}, {31'b0, m_req});
    if (m_req) begin
      chk("adr_bus", {16'b0, adr_bus},
          {16'b0, m_disc ? m_hold : m_pc});
    end
`ifdef FETCH_STATS_EN
    chk("fetch_cnt", fetch_cnt, m_cnt);
`endif
  endtask

  task automatic model_step();
    int sz;
    bit pop;
    sz  = q.size();
    pop = (sz > 0) && ins_ready && !flush;
    if (m_req && mem_rdy && (m_cnt != 32'hFFFF_FFFF)) begin
      m_cnt++;
    end
    if (flush) begin
      q.delete();
      if (m_req && !mem_rdy && !m_disc) begin
        m_hold = m_pc;
        m_disc = 1;
      end else if (m_disc && mem_rdy) begin
        m_disc = 0;
      end
      m_pc = flush_pc;
    end else begin
      if (pop) begin
        void'(q.pop_front());
      end
      if (m_req && mem_rdy) begin
        if (m_disc) begin
          m_disc = 0;
        end else begin
          q.push_back('{pc: m_pc, d: memf(m_pc)});
          m_pc++;
          m_req = (q.size() < DEPTH);
        end
      end else if (!m_req) begin
        m_req = (sz < DEPTH);
      end
    end
  endtask

  task automatic cycle();
    check_outputs();
    if (rd_mem && mem_rdy) begin
      n_done++;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_mem"}, {31'b0, rd_mem}, 32'd0);
    chk({tag, "_adr"}, {16'b0, adr_bus}, 32'd0);
    chk({tag, "_valid"}, {31'b0, ins_valid}, 32'd0);
    chk({tag, "_data"}, {16'b0, ins_data}, 32'd0);
    chk({tag, "_pc"}, {16'b0, ins_pc}, 32'd0);
`ifdef FETCH_STATS_EN
    chk({tag, "_cnt"}, fetch_cnt, 32'd0);
`endif
  endtask

  task automatic reset_mid(input string tag);
    #2 reset = 1'b0;
    #1 reset_checks(tag);
    m_reset();
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n0;
    logic [AW-1:0] a0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_checks("rst");
    reset = 1'b1;

    // streaming: one word per cycle
    mem_rdy   = 1'b1;
    ins_ready = 1'b1;
    repeat (10) cycle();
    chk("seq_valid", {31'b0, ins_valid}, 32'd1);
    chk("seq_pc", {16'b0, ins_pc}, 32'd8);
    repeat (10) cycle();

    // queue fills with no consumer, then one pop
    reset_mid("rst2");
    ins_ready = 1'b0;
    mem_rdy   = 1'b1;
    n0 = n_done;
    repeat (12) cycle();
    chk("fill_reads", n_done - n0, 32'd4);
    chk("fill_rd_mem", {31'b0, rd_mem}, 32'd0);
    ins_ready = 1'b1;
    cycle();
    ins_ready = 1'b0;
    n0 = n_done;
    repeat (10) cycle();
    chk("refill_reads", n_done - n0, 32'd1);

    // slow memory: request held while stalled
    ins_ready = 1'b1;
    mem_rdy   = 1'b0;
    for (int i = 0; i < 10 && !rd_mem; i++) cycle();
    chk("stall_req_seen", {31'b0, rd_mem}, 32'd1);
    a0 = adr_bus;
    for (int i = 0; i < 4; i++) begin
      mem_rdy = (i == 3);
      chk("stall_adr", {16'b0, adr_bus}, {16'b0, a0});
      chk("stall_rd", {31'b0, rd_mem}, 32'd1);
      cycle();
    end

    // flush during an outstanding read
    mem_rdy = 1'b0;
    for (int i = 0; i < 10 && !rd_mem; i++) cycle();
    chk("fl_req_seen", {31'b0, rd_mem}, 32'd1);
    flush    = 1'b1;
    flush_pc = 16'h0100;
    cycle();
    flush = 1'b0;
    chk("fl_no_stale", {31'b0, ins_valid}, 32'd0);
    repeat (2) cycle();
    mem_rdy = 1'b1;
    for (int i = 0; i < 10 && !ins_valid; i++) cycle();
    chk("fl_first_pc", {16'b0, ins_pc}, 32'h0100);

    // address wrap
    flush    = 1'b1;
    flush_pc = 16'hFFFE;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ins_valid && ins_pc == 16'hFFFF) break;
      cycle();
    end
    chk("wrap_top", {16'b0, ins_pc}, 32'hFFFF);
    cycle();
    chk("wrap_zero", {16'b0, ins_pc}, 32'h0000);
    chk("wrap_valid", {31'b0, ins_valid}, 32'd1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      mem_rdy   = ($urandom_range(0, 1) == 1);
      ins_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      flush_pc  = AW'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset_mid("rst_rand");
      end else begin
        cycle();
      end
    end

    // reset in the middle of a stalled read
    flush   = 1'b0;
    mem_rdy = 1'b0;
    for (int i = 0; i < 10 && !rd_mem; i++) cycle();
    chk("mid_req_seen", {31'b0, rd_mem}, 32'd1);
    reset_mid("rst_mid");
    cycle();
    chk("post_rst_rd", {31'b0, rd_mem}, 32'd1);
    chk("post_rst_adr", {16'b0, adr_bus}, 32'd0);
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
